// File: rtl/flash_spi_reader.sv
// flash_spi_reader
// Read-only SPI master (mode 0) for the boot/program flash. A request from
// the MMU issues a flash READ (0x03) with a 24-bit address and returns one
// 32-bit little-endian word together with a single-cycle rvalid_o pulse.
//
// Ports
//   clk          system clock
//   rst          asynchronous active-low reset
//   req_i        read request, held until accepted (req_i && ready_o)
//   addr_i       flash byte address, sampled only at accept
//   ready_o      block idle, able to accept
//   rvalid_o     one-cycle pulse, rdata_o valid
//   rdata_o      read word, held until the next rvalid_o
//   spi_cs_n_o   flash chip select, active-low
//   spi_sck_o    SPI clock, idle low
//   spi_mosi_o   command/address to flash
//   spi_miso_i   data from flash
module flash_spi_reader #(
    parameter int CLK_DIV = 2  // SCK half-period in clk cycles, 1..255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic [23:0] addr_i,
    output logic        ready_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        spi_cs_n_o,
    output logic        spi_sck_o,
    output logic        spi_mosi_o,
    input  logic        spi_miso_i
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [DIV_W-1:0] r_div;
    logic [6:0]       r_bit;     // completed bits, 0..64
    logic             r_sck;
    logic [31:0]      r_tx;
    logic [31:0]      r_rx;
    logic [31:0]      r_rdata;
    logic             w_accept;
    logic             w_div_end;
    logic             w_last_bit;

    assign w_accept   = req_i && (r_state == S_IDLE);
    assign w_div_end  = (r_div == DIV_LAST);
    assign w_last_bit = (r_bit == 7'd63);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_SETUP;
            S_SETUP: if (w_div_end) w_next = S_SHIFT;
            // A bit completes at the end of its SCK low phase.
            S_SHIFT: if (w_div_end && !r_sck && w_last_bit) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div   <= '0;
            r_bit   <= '0;
            r_sck   <= 1'b0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_tx  <= {8'h03, addr_i};
                        r_div <= '0;
                        r_bit <= '0;
                        r_sck <= 1'b0;
                    end
                end
                S_SETUP: begin
                    if (w_div_end) begin
                        // First rising SCK: sample MISO on the same edge.
                        r_div <= '0;
                        r_sck <= 1'b1;
                        r_rx  <= {r_rx[30:0], spi_miso_i};
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                S_SHIFT: begin
                    if (w_div_end) begin
                        r_div <= '0;
                        if (r_sck) begin
                            // Falling SCK: advance MOSI. Zero fill makes MOSI
                            // read 0 through the RX half.
                            r_sck <= 1'b0;
                            r_tx  <= {r_tx[30:0], 1'b0};
                        end else begin
                            r_bit <= r_bit + 7'd1;
                            if (!w_last_bit) begin
                                r_sck <= 1'b1;
                                r_rx  <= {r_rx[30:0], spi_miso_i};
                            end else begin
                                // First received byte sits in r_rx[31:24];
                                // return it as the least significant byte.
                                r_rdata <= {r_rx[7:0], r_rx[15:8],
                                            r_rx[23:16], r_rx[31:24]};
                            end
                        end
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready_o    = (r_state == S_IDLE);
    assign rvalid_o   = (r_state == S_DONE);
    assign rdata_o    = r_rdata;
    assign spi_cs_n_o = !((r_state == S_SETUP) || (r_state == S_SHIFT));
    assign spi_sck_o  = r_sck;
    assign spi_mosi_o = r_tx[31];

endmodule

// File: doc/flash_spi_reader.md
# flash_spi_reader

Read-only SPI master for the external boot/program flash, sitting directly downstream of `mmu` on its "Flash storage SPI" port. The MMU presents a 24-bit byte address. The block then issues a standard flash READ (0x03) transaction and returns one 32-bit little-endian word with a single-cycle valid pulse. It owns the flash pins; nothing else drives them.

## Interface
- `CLK_DIV`, default 2: SCK half-period in `clk` cycles; legal range 1..255.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `req_i`  in  1  read request from MMU; held until accepted.
- `addr_i`  in  24  flash byte address; sampled only at accept.
- `ready_o`  out  1  block idle; request accepted on a `clk` edge with `req_i && ready_o`.
- `rvalid_o`  out  1  one-cycle pulse; `rdata_o` valid.
- `rdata_o`  out  32  read word; holds its value until the next `rvalid_o`.
- `spi_cs_n_o`  out  1  flash chip select, active-low.
- `spi_sck_o`  out  1  SPI clock, mode 0 (idle low).
- `spi_mosi_o`  out  1  command/address data to flash.
- `spi_miso_i`  in  1  data from flash.

## Operation
- States:
  - IDLE → SETUP on accept.
  - SETUP → SHIFT after `CLK_DIV` cycles.
  - SHIFT → DONE after the 64th bit completes.
  - DONE → IDLE after 1 cycle.
- On accept, latch `{8'h03, addr_i}` into a 32-bit TX shift register. Send it MSB first, so 0x03 goes out first, then the address bytes high to low.
- SHIFT transfers 64 bits: 32 TX bits, then 32 RX bits. `spi_mosi_o` is 0 during the RX half.
- RX byte order is little-endian.
  - The first received byte is from `addr`; it lands in `rdata_o[7:0]`.
  - The fourth received byte lands in `rdata_o[31:24]`.
  - Within each byte, bits arrive MSB first.
- The block does not check address wrap. Flash-side wrap past 0xFFFFFF is the flash's behaviour.
- Counters:
  - Bit counter is 7 bits, range 0..64.
  - Divider counter is sized for `CLK_DIV-1`.
  - Both clear on entering SETUP.
- `req_i` and `addr_i` are ignored outside IDLE. A request is never queued, and is never dropped once accepted.

## Timing
- Reset values:
  - `ready_o`=1, `rvalid_o`=0, `rdata_o`=0.
  - `spi_cs_n_o`=1, `spi_sck_o`=0, `spi_mosi_o`=0.
  - State is IDLE.
- Reset asserted mid-transaction: all outputs take their reset values asynchronously and the transaction is abandoned with no `rvalid_o`.
- Take the accept edge as the end of cycle 0.
- SETUP, cycles 1..`CLK_DIV`:
  - `spi_cs_n_o`=0, `spi_sck_o`=0.
  - `spi_mosi_o` = TX bit 31.
  - `ready_o`=0.
- SHIFT, per bit:
  - `spi_sck_o` is high for `CLK_DIV` cycles, then low for `CLK_DIV` cycles.
  - `spi_miso_i` is sampled on the `clk` edge that drives `spi_sck_o` high.
  - `spi_mosi_o` advances on the `clk` edge that drives `spi_sck_o` low, so it is stable across every rising SCK.
- SCK period is `2*CLK_DIV` cycles; SHIFT lasts `128*CLK_DIV` cycles.
- DONE is cycle `129*CLK_DIV+1`:
  - `spi_cs_n_o`=1, `spi_sck_o`=0.
  - `rvalid_o`=1 and `rdata_o` updated.
  - `ready_o`=0.
- Request-to-data latency is therefore 259 cycles at `CLK_DIV`=2 and 130 cycles at `CLK_DIV`=1.
- `ready_o` returns to 1 in the cycle after DONE.
- If `req_i` is held high, the next accept occurs in that cycle. Minimum CS# high time is therefore 2 cycles (DONE plus the accept cycle).
- No SCK edges occur while `spi_cs_n_o`=1.
- Exactly 64 rising SCK edges occur per transaction.

## Test plan
- **Reset:**
  - Stimulus: assert `rst`=0 asynchronously mid-cycle.
  - Response: `spi_cs_n_o`=1, `spi_sck_o`=0, `ready_o`=1, `rvalid_o`=0 without waiting for a `clk` edge.
- **Single read, `CLK_DIV`=2:**
  - Stimulus: `addr_i`=0x001234; flash model returns 0xEF,0xBE,0xAD,0xDE.
  - Response: MOSI stream 0x03,0x00,0x12,0x34; 64 rising SCK edges; `rvalid_o` only at cycle 259 with `rdata_o`=0xDEADBEEF.
- **Back-to-back reads:**
  - Stimulus: `req_i` held high, addresses 0x000000 then 0x000004.
  - Response: second accept at cycle 260; CS# high exactly 2 cycles between transactions; both words correct.
- **Busy-time stimulus ignored:**
  - Stimulus: toggle `req_i` and change `addr_i` to 0xABCDEF during SHIFT.
  - Response: address bytes on MOSI unchanged; exactly one `rvalid_o` pulse.
- **Reset mid-shift:**
  - Stimulus: assert reset after 20 SCK rising edges.
  - Response: CS# high and SCK low immediately; no `rvalid_o`; a following read of 0x000010 returns the correct word.
- **`CLK_DIV`=1:**
  - Stimulus: `addr_i`=0xFFFFFC; flash model returns 0x78,0x56,0x34,0x12.
  - Response: SCK period 2 cycles; `rvalid_o` at cycle 130 with `rdata_o`=0x12345678.
